block_matrix_engine: RTL and testbench
======================================

# block_matrix_engine

Self-contained blocked matrix multiplier: computes C = A × B for square N×N signed matrices, with N = 2·`dim_blocks` chosen at run time, by iterating 2×2 block products over an external single-port RAM. It folds the control unit, 2×2 MAC and block accumulator into one parametrised engine. The RAM stays outside the block, and the engine drives its address, write-enable and write-data ports directly.

## Interface
- `DATA_W`, 32, element and RAM word width (signed two's complement)
- `ADDR_W`, 9, RAM address width; RAM depth = 2^ADDR_W
- `DIM_W`, 4, width of `dim_blocks`
- `clk` in 1: the single clock; all logic on rising edge
- `rst` in 1: synchronous, active-high reset
- `start` in 1: begin operation; sampled only in IDLE
- `dim_blocks` in DIM_W: matrix size in 2×2 blocks (nb); latched on accepted `start`
- `ram_r_data` in DATA_W: RAM read data, valid 1 cycle after address
- `ram_addr` out ADDR_W: RAM address
- `ram_we` out 1: RAM write enable
- `ram_w_data` out DATA_W: RAM write data
- `ram_writing` out 1: equal to `ram_we`
- `busy` out 1: operation in progress
- `done` out 1: one-cycle completion pulse (success or error)
- `err` out 1: configuration error, sticky until next accepted `start`
- `block_complete` out 1: one-cycle pulse on the last write of each C block
- `ovf` out 1: sticky saturation flag (see Configuration)

## Operation
- Memory map, N = 2·nb, row-major:
  - A[r][c] at r·N+c
  - B at N²+r·N+c
  - C at 2N²+r·N+c
- N² is computed once in CHECK. The CHECK comparison uses ≥2·DIM_W+4 bits.
- States: IDLE → CHECK → {ERR | FETCH} ; FETCH → MAC → {FETCH (next k) | WRITE} ; WRITE → {FETCH (next block) | FIN} ; ERR, FIN → IDLE.
- CHECK fails if nb = 0 or 12·nb² > 2^ADDR_W. On failure:
  - ERR state for one cycle: `done`=1, `err`=1.
  - No RAM access.
- Output blocks (bi,bj) are visited in row-major order. For each block, k runs from 0 to nb−1. Each k step:
  - FETCH reads the A(bi,k) block (a11,a12,a21,a22), then the B(k,bj) block (b11,b12,b21,b22).
  - MAC adds the 2×2 product into the accumulator: c_ij += a_i1·b_1j + a_i2·b_2j.
- The accumulator clears at the start of each output block. No cycle is spent on the clear.
- WRITE stores c11, c12, c21, c22 in that address order. `block_complete` pulses with the c22 write.
- Arithmetic without the macro:
  - Products are truncated to the low DATA_W bits.
  - Sums wrap modulo 2^DATA_W.
- `start` while busy is ignored. `dim_blocks` changes after acceptance have no effect.
- Reset mid-operation: the next state is IDLE. All outputs are 0 and `ram_we` deasserts at that edge. Accumulator contents and partial C words already written are abandoned.

## Timing
- Reset value of every output is 0. `ram_addr` is 0 in IDLE.
- `start` high in IDLE at edge t → CHECK during cycle t+1. `busy`=1 from CHECK through FIN/ERR inclusive.
- FETCH lasts 9 cycles:
  - Addresses are issued in cycles 0–7 (4 A, then 4 B).
  - Data is captured in cycles 1–8.
- MAC lasts 1 cycle and is registered. WRITE lasts 4 cycles with `ram_we`=1 in each. FIN lasts 1 cycle with `done`=1.
- Busy duration:
  - Success: 2 + nb²·(10·nb+4) cycles.
  - Error: 2 cycles.
- Earliest re-start: `start` sampled the cycle after `done`.

## Configuration
- `MATMUL_SATURATE_EN` defined:
  - Products and accumulation are computed at 2·DATA_W+2 bits.
  - Each accumulate step clamps to [−2^(DATA_W−1), 2^(DATA_W−1)−1].
  - Any clamp sets `ovf`, which holds until the next accepted `start`.
- Undefined: wrap-around arithmetic as above, and `ovf` tied to 0.

## Test plan
- nb=1, A=[[1,2],[3,4]] at 0–3, B=[[5,6],[7,8]] at 4–7 → RAM 8–11 = 19,22,43,50.
  - Also check: `busy` 16 cycles, one `block_complete`, `done` pulse, `err`=0.
- nb=2, A=identity (4×4), B = values 1..16 → C at 32–47 = 1..16.
  - Also check: 4 `block_complete` pulses, busy 2+4·24 = 98 cycles.
- nb=0, then nb=7 with ADDR_W=9 → each run gives `err`=1, `done` pulse 2 cycles after start, `ram_we` never asserted.
- nb=6 (maximum, 432 words) with random signed data → C matches a golden model with wrap arithmetic; `ovf`=0 when built without the macro.
- `rst` asserted mid-FETCH of nb=2 → next cycle all outputs 0 and IDLE. A following nb=1 run gives correct results.
- With `MATMUL_SATURATE_EN`, DATA_W=32, nb=1, A=B all 0x7FFFFFFF → C words = 0x7FFFFFFF, `ovf`=1. The next `start` clears `ovf`.

Source files
------------

// File: rtl/block_matrix_engine.sv
// Blocked signed matrix multiplier C = A x B over an external single-port RAM, walking 2x2 block products.
// Optional feature macro MATMUL_SATURATE_EN: saturating accumulation with a sticky ovf flag.
module block_matrix_engine #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9,
  parameter int DIM_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DIM_W-1:0]  dim_blocks,
  input  logic [DATA_W-1:0] ram_r_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_w_data,
  output logic              ram_writing,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              block_complete,
  output logic              ovf
);
  localparam int CW = (2*DIM_W+4 > ADDR_W+1) ? 2*DIM_W+4 : ADDR_W+1;
`ifdef MATMUL_SATURATE_EN
  localparam int WW = 2*DATA_W+2;
  localparam logic signed [WW-1:0] SAT_MAX = {{(WW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [WW-1:0] SAT_MIN = {{(WW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
`endif

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0, S_CHECK = 3'd1, S_ERR   = 3'd2, S_FETCH = 3'd3,
    S_MAC   = 3'd4, S_WRITE = 3'd5, S_FIN   = 3'd6
  } state_t;

  state_t                     state_q;
  logic [DIM_W-1:0]           nb_q, bi_q, bj_q, k_q;
  logic [ADDR_W-1:0]          n_sq_q;
  logic [3:0]                 cnt_q;
  logic signed [DATA_W-1:0]   opnd_q [8];
  logic signed [DATA_W-1:0]   acc_q [4];
  logic [DATA_W:0]            step_s [4];
  logic [CW-1:0]              nb_sq_s;
  logic                       cfg_bad_s, clamp_s;
  logic [ADDR_W-1:0]          ram_addr_q;
  logic [DATA_W-1:0]          ram_w_data_q;
  logic                       ram_we_q, busy_q, done_q, err_q, block_complete_q, ovf_q;

  // One accumulate step for a C element; the MSB of the result flags a clamp.
  function automatic logic [DATA_W:0] acc_step(input logic signed [DATA_W-1:0] acc, input logic clr,
                                               input logic signed [DATA_W-1:0] a1, input logic signed [DATA_W-1:0] a2,
                                               input logic signed [DATA_W-1:0] b1, input logic signed [DATA_W-1:0] b2);
`ifdef MATMUL_SATURATE_EN
    logic signed [WW-1:0] base;
    logic signed [WW-1:0] sum;
    base = clr ? {WW{1'b0}} : WW'(acc);
    sum  = base + WW'(a1) * WW'(b1) + WW'(a2) * WW'(b2);
    if (sum > SAT_MAX) begin
      acc_step = {1'b1, SAT_MAX[DATA_W-1:0]};
    end else if (sum < SAT_MIN) begin
      acc_step = {1'b1, SAT_MIN[DATA_W-1:0]};
    end else begin
      acc_step = {1'b0, sum[DATA_W-1:0]};
    end
`else
    logic signed [DATA_W-1:0] base;
    base = clr ? {DATA_W{1'b0}} : acc;
    acc_step = {1'b0, base + a1 * b1 + a2 * b2};
`endif
  endfunction

  // Address of operand idx (0-3 A block, 4-7 B block) for k-step k of output block (bi,bj).
  function automatic logic [ADDR_W-1:0] fetch_addr(input logic [ADDR_W-1:0] nsq, input logic [DIM_W-1:0] bi,
                                                   input logic [DIM_W-1:0] bj, input logic [DIM_W-1:0] k,
                                                   input logic [2:0] idx);
    logic [ADDR_W-1:0] n, base;
    n = ADDR_W'({nb_q, 1'b0});
    if (!idx[2]) begin
      base = ADDR_W'({bi, 1'b0}) * n + ADDR_W'({k, 1'b0});
    end else begin
      base = nsq + ADDR_W'({k, 1'b0}) * n + ADDR_W'({bj, 1'b0});
    end
    fetch_addr = base + (idx[1] ? n : {ADDR_W{1'b0}}) + ADDR_W'(idx[0]);
  endfunction

  function automatic logic [ADDR_W-1:0] c_addr(input logic [DIM_W-1:0] bi, input logic [DIM_W-1:0] bj,
                                               input logic [1:0] idx);
    logic [ADDR_W-1:0] n;
    n = ADDR_W'({nb_q, 1'b0});
    c_addr = (n_sq_q << 1) + ADDR_W'({bi, 1'b0}) * n + ADDR_W'({bj, 1'b0})
             + (idx[1] ? n : {ADDR_W{1'b0}}) + ADDR_W'(idx[0]);
  endfunction

  assign nb_sq_s   = CW'(nb_q) * CW'(nb_q);
  assign cfg_bad_s = (nb_q == {DIM_W{1'b0}}) || ((nb_sq_s * CW'(12)) > (CW'(1) << ADDR_W));

  // The accumulator restarts from zero on the first k step of each output block.
  assign step_s[0] = acc_step(acc_q[0], k_q == {DIM_W{1'b0}}, opnd_q[0], opnd_q[1], opnd_q[4], opnd_q[6]);
  assign step_s[1] = acc_step(acc_q[1], k_q == {DIM_W{1'b0}}, opnd_q[0], opnd_q[1], opnd_q[5], opnd_q[7]);
  assign step_s[2] = acc_step(acc_q[2], k_q == {DIM_W{1'b0}}, opnd_q[2], opnd_q[3], opnd_q[4], opnd_q[6]);
  assign step_s[3] = acc_step(acc_q[3], k_q == {DIM_W{1'b0}}, opnd_q[2], opnd_q[3], opnd_q[5], opnd_q[7]);
  assign clamp_s   = step_s[0][DATA_W] | step_s[1][DATA_W] | step_s[2][DATA_W] | step_s[3][DATA_W];

  // Control FSM with registered RAM-side and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      nb_q <= '0; bi_q <= '0; bj_q <= '0; k_q <= '0; cnt_q <= 4'd0; n_sq_q <= '0;
      ram_addr_q <= '0; ram_w_data_q <= '0; ram_we_q <= 1'b0;
      busy_q <= 1'b0; done_q <= 1'b0; err_q <= 1'b0; block_complete_q <= 1'b0; ovf_q <= 1'b0;
      for (int i = 0; i < 8; i++) opnd_q[i] <= '0;
      for (int i = 0; i < 4; i++) acc_q[i] <= '0;
    end else begin
      done_q <= 1'b0; block_complete_q <= 1'b0; ram_we_q <= 1'b0;
      ram_addr_q <= '0; ram_w_data_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            nb_q <= dim_blocks; err_q <= 1'b0; ovf_q <= 1'b0; busy_q <= 1'b1;
            state_q <= S_CHECK;
          end
        end
        S_CHECK: begin
          n_sq_q <= ADDR_W'(nb_sq_s << 2);
          bi_q <= '0; bj_q <= '0; k_q <= '0; cnt_q <= 4'd0;
          if (cfg_bad_s) begin
            state_q <= S_ERR; done_q <= 1'b1; err_q <= 1'b1;
          end else begin
            state_q <= S_FETCH;
            ram_addr_q <= fetch_addr(ADDR_W'(nb_sq_s << 2), '0, '0, '0, 3'd0);
          end
        end
        S_FETCH: begin
          // Read data lags its address by one cycle, so capture index trails cnt_q by one.
          if (cnt_q != 4'd0) opnd_q[3'(cnt_q - 4'd1)] <= ram_r_data;
          if (cnt_q == 4'd8) begin
            cnt_q <= 4'd0; state_q <= S_MAC;
          end else begin
            cnt_q <= cnt_q + 4'd1;
            if (cnt_q < 4'd7) ram_addr_q <= fetch_addr(n_sq_q, bi_q, bj_q, k_q, cnt_q[2:0] + 3'd1);
          end
        end
        S_MAC: begin
          for (int i = 0; i < 4; i++) acc_q[i] <= step_s[i][DATA_W-1:0];
          ovf_q <= ovf_q | clamp_s;
          if (k_q == nb_q - DIM_W'(1)) begin
            state_q <= S_WRITE; ram_we_q <= 1'b1;
            ram_addr_q <= c_addr(bi_q, bj_q, 2'd0); ram_w_data_q <= step_s[0][DATA_W-1:0];
          end else begin
            k_q <= k_q + DIM_W'(1); state_q <= S_FETCH;
            ram_addr_q <= fetch_addr(n_sq_q, bi_q, bj_q, k_q + DIM_W'(1), 3'd0);
          end
        end
        S_WRITE: begin
          if (cnt_q != 4'd3) begin
            cnt_q <= cnt_q + 4'd1; ram_we_q <= 1'b1;
            ram_addr_q <= c_addr(bi_q, bj_q, cnt_q[1:0] + 2'd1);
            ram_w_data_q <= acc_q[cnt_q[1:0] + 2'd1];
            block_complete_q <= (cnt_q == 4'd2);
          end else begin
            cnt_q <= 4'd0; k_q <= '0;
            if (bj_q != nb_q - DIM_W'(1)) begin
              bj_q <= bj_q + DIM_W'(1); state_q <= S_FETCH;
              ram_addr_q <= fetch_addr(n_sq_q, bi_q, bj_q + DIM_W'(1), '0, 3'd0);
            end else if (bi_q != nb_q - DIM_W'(1)) begin
              bi_q <= bi_q + DIM_W'(1); bj_q <= '0; state_q <= S_FETCH;
              ram_addr_q <= fetch_addr(n_sq_q, bi_q + DIM_W'(1), '0, '0, 3'd0);
            end else begin
              state_q <= S_FIN; done_q <= 1'b1;
            end
          end
        end
        S_ERR, S_FIN: begin
          busy_q <= 1'b0; state_q <= S_IDLE;
        end
        default: begin
          busy_q <= 1'b0; state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ram_addr       = ram_addr_q;
  assign ram_we         = ram_we_q;
  assign ram_writing    = ram_we_q;
  assign ram_w_data     = ram_w_data_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;
  assign block_complete = block_complete_q;
  assign ovf            = ovf_q;
endmodule

// File: tb/tb_block_matrix_engine.sv
// Self-checking bench: a plain matrix-product model predicts every C write, busy length and flags.
module tb_block_matrix_engine;
  logic        clk = 1'b0;
  logic        rst, start;
  logic [3:0]  dim_blocks;
  logic [31:0] ram_r_data;
  logic [8:0]  ram_addr;
  logic        ram_we, ram_writing, busy, done, err, block_complete, ovf;
  logic [31:0] ram_w_data;

  logic [31:0] mem [512];
  logic        ld_en;
  logic [8:0]  ld_addr;
  logic [31:0] ld_data;

  typedef struct { logic [8:0] addr; logic [31:0] data; bit last; } wr_t;
  wr_t exp_q[$];
  int  checks = 0, failures = 0, bc_cnt = 0, we_cnt = 0;
  bit  mon_en = 1'b0;

  block_matrix_engine dut (
    .clk(clk), .rst(rst), .start(start), .dim_blocks(dim_blocks), .ram_r_data(ram_r_data),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_w_data(ram_w_data), .ram_writing(ram_writing),
    .busy(busy), .done(done), .err(err), .block_complete(block_complete), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM with a side port the bench uses to preload data.
  always @(posedge clk) begin
    ram_r_data <= mem[ram_addr];
    if (ram_we) mem[ram_addr] <= ram_w_data;
    else if (ld_en) mem[ld_addr] <= ld_data;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic poke(input int a, input logic [31:0] d);
    ld_en = 1'b1; ld_addr = a[8:0]; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  // Reference: C = A x B block by block, each k step accumulated at 66 bits then wrapped or clamped.
  task automatic build_expected(input int nb, output bit ovf_exp);
    int n, r, c;
    logic signed [65:0] acc [4];
    logic signed [65:0] s, smax, smin;
    wr_t w;
    n = 2 * nb; ovf_exp = 1'b0;
    smax = 66'sd2147483647; smin = -66'sd2147483648;
    for (int bi = 0; bi < nb; bi++) begin
      for (int bj = 0; bj < nb; bj++) begin
        for (int e = 0; e < 4; e++) acc[e] = 66'sd0;
        for (int k = 0; k < nb; k++) begin
          for (int e = 0; e < 4; e++) begin
            r = 2 * bi + e / 2; c = 2 * bj + e % 2;
            s = acc[e] + $signed(mem[r*n + 2*k]) * $signed(mem[n*n + (2*k)*n + c])
                       + $signed(mem[r*n + 2*k + 1]) * $signed(mem[n*n + (2*k+1)*n + c]);
`ifdef MATMUL_SATURATE_EN
            if (s > smax) begin s = smax; ovf_exp = 1'b1; end
            else if (s < smin) begin s = smin; ovf_exp = 1'b1; end
`else
            s = {{34{s[31]}}, s[31:0]};
`endif
            acc[e] = s;
          end
        end
        for (int e = 0; e < 4; e++) begin
          w.addr = 9'(2*n*n + (2*bi + e/2)*n + 2*bj + e%2);
          w.data = acc[e][31:0];
          w.last = (e == 3);
          exp_q.push_back(w);
        end
      end
    end
  endtask

  // Compare process: every RAM write and every status output checked against the model.
  always @(negedge clk) begin
    if (mon_en) begin
      wr_t e;
      chk("ram_writing", ram_writing, ram_we);
      if (ram_we === 1'b1) begin
        we_cnt++;
        chk("write_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("wr_addr", ram_addr, e.addr);
          chk("wr_data", ram_w_data, e.data);
          chk("block_complete", block_complete, e.last);
        end
        if (block_complete === 1'b1) bc_cnt++;
      end else begin
        chk("bc_without_write", block_complete, 0);
        if (busy !== 1'b1) chk("idle_addr", ram_addr, 0);
      end
`ifndef MATMUL_SATURATE_EN
      chk("ovf_zero", ovf, 0);
`endif
    end
  end

  task automatic run(input int nb, input bit exp_err);
    int cyc, done_seen, done_at, bc0, we0, exp_busy;
    bit ovf_exp;
    ovf_exp = 1'b0;
    if (!exp_err) build_expected(nb, ovf_exp);
    exp_busy = exp_err ? 2 : 2 + nb*nb*(10*nb + 4);
    bc0 = bc_cnt; we0 = we_cnt;
    start = 1'b1; dim_blocks = nb[3:0];
    @(negedge clk);
    start = 1'b0; dim_blocks = 4'd0;
    cyc = 0; done_seen = 0; done_at = 0;
    while (busy === 1'b1 && cyc < 20000) begin
      cyc++;
      if (done === 1'b1) begin done_seen++; done_at = cyc; end
      if (cyc == 5) begin start = 1'b1; dim_blocks = 4'd3; end
      else if (cyc == 6) begin start = 1'b0; dim_blocks = 4'd0; end
      @(negedge clk);
    end
    start = 1'b0;
    chk("busy_cycles", cyc, exp_busy);
    chk("done_pulses", done_seen, 1);
    chk("done_at_end", done_at, cyc);
    chk("done_low_idle", done, 0);
    chk("err", err, exp_err);
    chk("ovf", ovf, ovf_exp);
    chk("block_completes", bc_cnt - bc0, exp_err ? 0 : nb*nb);
    chk("writes", we_cnt - we0, exp_err ? 0 : 4*nb*nb);
    chk("pending_writes", exp_q.size(), 0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_ovf"}, ovf, 0);
    chk({tag, "_bc"}, block_complete, 0);
    chk({tag, "_we"}, ram_we, 0);
    chk({tag, "_writing"}, ram_writing, 0);
    chk({tag, "_addr"}, ram_addr, 0);
    chk({tag, "_wdata"}, ram_w_data, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; dim_blocks = 4'd0;
    ld_en = 1'b0; ld_addr = 9'd0; ld_data = 32'd0;
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    rst = 1'b0; mon_en = 1'b1;

    // 2x2 product with hand-known result
    for (int i = 0; i < 8; i++) poke(i, 32'(i + 1));
    run(1, 1'b0);
    chk("t1_c11", mem[8], 32'd19);
    chk("t1_c12", mem[9], 32'd22);
    chk("t1_c21", mem[10], 32'd43);
    chk("t1_c22", mem[11], 32'd50);

    // identity times 1..16
    for (int i = 0; i < 16; i++) begin
      poke(i, (i / 4 == i % 4) ? 32'd1 : 32'd0);
      poke(16 + i, 32'(i + 1));
    end
    run(2, 1'b0);
    for (int i = 0; i < 16; i++) chk("t2_c", mem[32 + i], 32'(i + 1));

    // configuration errors
    run(0, 1'b1);
    run(7, 1'b1);

    // largest legal size with random signed data
    for (int i = 0; i < 432; i++) poke(i, $urandom);
    run(6, 1'b0);

    // reset in the middle of a FETCH
    start = 1'b1; dim_blocks = 4'd2;
    @(negedge clk);
    start = 1'b0; dim_blocks = 4'd0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_outputs_zero("midrst");
    rst = 1'b0;
    for (int i = 0; i < 8; i++) poke(i, 32'($urandom_range(0, 2000)) - 32'd1000);
    run(1, 1'b0);

`ifdef MATMUL_SATURATE_EN
    for (int i = 0; i < 8; i++) poke(i, 32'h7FFF_FFFF);
    run(1, 1'b0);
    for (int i = 0; i < 4; i++) chk("sat_c", mem[8 + i], 32'h7FFF_FFFF);
    chk("sat_ovf_set", ovf, 1);
    run(0, 1'b1);
    chk("sat_ovf_cleared", ovf, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
